// File: rtl/cs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cs_pkg
// Purpose  : Shared sizes and types for the circular-shift sequencing controller.
// Revision : 1.0 - initial release
// ============================================================================
package cs_pkg;

    localparam int CS_WIDTH = 32;
    localparam int CS_AMT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } cs_state_t;

    typedef logic [CS_WIDTH-1:0] cs_word_t;

endpackage : cs_pkg
`default_nettype wire

// File: rtl/cs_if.sv
`default_nettype none
// ============================================================================
// Module   : cs_if
// Purpose  : Request/result handshake bundle between a requester and cs_ctrl.
//            Optional macro CS_LEFT_EN adds the in_dir direction signal.
// Revision : 1.0 - initial release
// ============================================================================
interface cs_if
    import cs_pkg::*;
#(
    parameter int WIDTH = CS_WIDTH,
    parameter int AMT_W = CS_AMT_W
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
`ifdef CS_LEFT_EN
    logic             in_dir;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

`ifdef CS_LEFT_EN
    modport master (
        output in_valid, in_data, in_amt, in_dir, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_dir, out_ready,
        output in_ready, out_valid, out_data, busy
    );
`else
    modport master (
        output in_valid, in_data, in_amt, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_amt, out_ready,
        output in_ready, out_valid, out_data, busy
    );
`endif

endinterface : cs_if
`default_nettype wire

// File: rtl/cs_step.sv
`default_nettype none
// ============================================================================
// Module   : cs_step
// Purpose  : Combinational one-position rotator; i_dir = 1 rotates left,
//            i_dir = 0 rotates right.
// Revision : 1.0 - initial release
// ============================================================================
module cs_step
    import cs_pkg::*;
(
    input  wire cs_word_t i_data,
    input  wire logic     i_dir,
    output cs_word_t      o_data
);

    cs_word_t w_rot_right;
    cs_word_t w_rot_left;

    assign w_rot_right = {i_data[0], i_data[CS_WIDTH-1:1]};
    assign w_rot_left  = {i_data[CS_WIDTH-2:0], i_data[CS_WIDTH-1]};
    assign o_data      = i_dir ? w_rot_left : w_rot_right;

endmodule : cs_step
`default_nettype wire

// File: rtl/cs_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cs_ctrl
// Purpose  : Sequences the single-step rotator to perform 0..31 position
//            rotates over valid/ready request and result handshakes.
//            Optional macro CS_LEFT_EN enables left rotation via in_dir.
// Revision : 1.0 - initial release
// ============================================================================
module cs_ctrl
    import cs_pkg::*;
#(
    parameter int WIDTH = CS_WIDTH,
    parameter int AMT_W = CS_AMT_W
) (
    input  wire logic clock,
    input  wire logic reset,
    cs_if.slave       bus
);

    cs_state_t        r_state;
    logic [WIDTH-1:0] r_data;
    logic [AMT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    cs_word_t         w_step;
    logic             w_dir;

`ifdef CS_LEFT_EN
    logic r_dir;
    assign w_dir = r_dir;
`else
    assign w_dir = 1'b0;
`endif

    cs_step u_step (
        .i_data (r_data),
        .i_dir  (w_dir),
        .o_data (w_step)
    );

    // Handshake flags are registered alongside the state so they carry no
    // combinational path from any input.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef CS_LEFT_EN
            r_dir       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_data     <= bus.in_data;
                        r_cnt      <= bus.in_amt;
`ifdef CS_LEFT_EN
                        r_dir      <= bus.in_dir;
`endif
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (bus.in_amt == '0) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    r_data <= w_step;
                    r_cnt  <= r_cnt - AMT_W'(1);
                    if (r_cnt == AMT_W'(1)) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.out_data  = r_data;

endmodule : cs_ctrl
`default_nettype wire

// File: tb/tb_cs_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cs_ctrl
// Purpose  : Directed self-checking bench for cs_ctrl (CS_LEFT_EN optional).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cs_ctrl;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    cs_if bus ();

    cs_ctrl dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, then count edges until out_valid rises.
    task automatic run(input string tag, input logic [31:0] d, input logic [4:0] a,
                       input logic [31:0] exp);
        int n;
        chk({tag, " in_ready before"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
        tick();
        bus.in_valid = 1'b0;
        chk({tag, " in_ready after accept"}, 32'(bus.in_ready), 32'd0);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(a));
        chk({tag, " out_data"}, bus.out_data, exp);
    endtask

    task automatic take(input string tag);
        bus.out_ready = 1'b1;
        tick();
        chk({tag, " idle in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, " idle out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, " idle busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.out_ready = 1'b0;
`ifdef CS_LEFT_EN
        bus.in_dir    = 1'b0;
`endif
        tick();
        tick();
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst out_data", bus.out_data, 32'h0);
        rst = 1'b0;
        tick();

        // Basic right rotate by one
        bus.out_ready = 1'b1;
        run("rot1", 32'h0000_0001, 5'd1, 32'h8000_0000);
        take("rot1");

        // Zero amount: DONE directly after acceptance
        run("amt0", 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
        chk("amt0 busy", 32'(bus.busy), 32'd1);
        take("amt0");

        // Full-range wrap
        run("amt31", 32'h8000_0000, 5'd31, 32'h0000_0001);
        take("amt31");

        // Backpressure with in_valid pulsing while result is held
        bus.out_ready = 1'b0;
        run("bp", 32'h0000_000F, 5'd4, 32'hF000_0000);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0] ? 1'b0 : 1'b1;
            bus.in_data  = 32'h5555_AAAA;
            bus.in_amt   = 5'd3;
            tick();
            chk("bp hold data", bus.out_data, 32'hF000_0000);
            chk("bp hold valid", 32'(bus.out_valid), 32'd1);
            chk("bp hold in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        take("bp");
        tick();
        chk("bp no extra busy", 32'(bus.busy), 32'd0);

        // Reset during the third SHIFT cycle
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hCAFE_0001;
        bus.in_amt   = 5'd8;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("mid busy before rst", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid rst busy", 32'(bus.busy), 32'd0);
        chk("mid rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid rst out_data", bus.out_data, 32'h0);
        chk("mid rst in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        run("after rst", 32'h0000_0100, 5'd8, 32'h0000_0001);
        take("after rst");

`ifdef CS_LEFT_EN
        bus.in_dir = 1'b1;
        run("left4", 32'h1234_5678, 5'd4, 32'h2345_6781);
        take("left4");
        bus.in_dir = 1'b0;
        run("right4", 32'h1234_5678, 5'd4, 32'h8123_4567);
        take("right4");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_cs_ctrl
`default_nettype wire

// File: doc/cs_ctrl.md
# cs_ctrl

Sequencing controller for the 32-bit one-position circular shifter. It accepts a word and a rotate amount over a valid/ready handshake, then drives the shifter one position per clock until the requested amount is reached. It returns the result over a second valid/ready handshake. It sits between a requesting unit (ALU/shift-test harness) and the single-step rotate datapath, so arbitrary rotates reuse the existing 1-bit circular shift.

## Interface
Parameters:
- WIDTH, 32, data width; fixed at 32 for this design.
- AMT_W, 5, rotate-amount width (log2 WIDTH).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  controller can accept a request (high only in IDLE).
- in_data  in  WIDTH  word to rotate.
- in_amt  in  AMT_W  rotate amount, 0..31.
- in_dir  in  1  0 = rotate right, 1 = rotate left. Present only with CS_LEFT_EN.
- out_valid  out  1  result available (high only in DONE).
- out_ready  in  1  consumer takes the result.
- out_data  out  WIDTH  rotated word.
- busy  out  1  high in SHIFT or DONE.

## Operation
- Registers:
  - data_q[WIDTH-1:0]
  - cnt_q[AMT_W-1:0]
  - dir_q (macro only)
  - state_q in {IDLE, SHIFT, DONE}.
- Rotate right by one: bit i ← bit i+1 for i = 0..30; bit 31 ← bit 0.
- Rotate left by one: bit i ← bit i−1; bit 0 ← bit 31.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at an edge: data_q ← in_data, cnt_q ← in_amt, dir_q ← in_dir.
  - Next state is DONE if in_amt == 0, else SHIFT.
- SHIFT:
  - Each edge: data_q ← step(data_q), cnt_q ← cnt_q − 1.
  - When cnt_q == 1 at the edge, the last step is taken and the next state is DONE.
  - in_valid is ignored.
- DONE:
  - out_valid = 1; out_data = data_q, held stable.
  - On out_ready at an edge: go to IDLE.
  - No new request is accepted in the same cycle (in_ready = 0).
- out_data equals data_q in every state. It is meaningful only while out_valid = 1.
- Arithmetic: cnt_q decrement is AMT_W-bit. It never wraps, because SHIFT is never entered with cnt_q == 0.

## Timing
- Reset values:
  - state_q = IDLE, data_q = 0, cnt_q = 0, dir_q = 0.
  - out_valid = 0, out_data = 0, busy = 0.
  - in_ready = 1, since it is decoded from IDLE. No request is accepted while reset is asserted.
- Latency: if the request is accepted at edge E0, out_valid rises after edge E0+amt. For amt = 0 it rises in the cycle immediately after acceptance.
- Throughput: at most one transaction per amt+2 cycles, minimum 2 (amt = 0, out_ready held high).
- out_valid and out_data are held until accepted. out_ready is a don't-care outside DONE.
- Reset mid-operation: the in-flight transaction is discarded with no output. All registers return to their reset values asynchronously.
- in_ready, out_valid and busy are pure decodes of state_q, with no combinational path from inputs.

## Configuration
- CS_LEFT_EN defined:
  - in_dir port exists and is captured into dir_q.
  - The step function selects rotate left when dir_q = 1.
- CS_LEFT_EN undefined:
  - in_dir port and dir_q are absent.
  - The step is always rotate right by one.
  - All other behaviour and timing are identical.

## Structure
- Package cs_pkg holds:
  - CS_WIDTH = 32 and CS_AMT_W = 5.
  - Typedef cs_state_t enum {IDLE, SHIFT, DONE}.
  - Typedef cs_word_t (logic [31:0]).
- One sub-module, cs_step:
  - Purely combinational one-position rotator: data in, dir in, data out.
  - dir is tied to 0 when CS_LEFT_EN is undefined.
  - The controller instantiates it once, feeding data_q.

## Test plan
- Basic right rotate: in_data = 0x00000001, amt = 1, out_ready = 1 → out_data = 0x80000000, out_valid one cycle after the edge following acceptance.
- Zero amount: in_data = 0xDEADBEEF, amt = 0 → out_valid in the cycle after acceptance, out_data = 0xDEADBEEF, no SHIFT state visited.
- Full-range wrap: in_data = 0x80000000, amt = 31 → out_valid 31 edges after acceptance, out_data = 0x00000001.
- Backpressure: 0x0000000F, amt = 4, out_ready held low for 5 cycles while in_valid pulses → out_data = 0xF0000000 stable, out_valid = 1, in_ready = 0, and no extra transaction is accepted.
- Reset mid-operation: amt = 8 request, reset asserted on the 3rd SHIFT cycle → immediately busy = 0, out_valid = 0, out_data = 0, in_ready = 1. A following request of 0x00000100, amt = 8 then returns 0x00000001.
- CS_LEFT_EN only: in_data = 0x12345678, amt = 4, in_dir = 1 → out_data = 0x23456781. The same request with in_dir = 0 → out_data = 0x81234567.
